riscv_core_dcache_writeback_buffer: RTL
=======================================

Name: riscv_core_dcache_writeback_buffer

Overview:
- Transmit side of the data-cache block path. The cache data memory fills 256-bit lines from AXI; this block sends evicted dirty lines back out.
- Accepts one victim line plus its address from the dcache controller and issues it as a single AXI4 INCR write burst on a narrower bus (AW, then W beats, then B).
- Holds the line until the B response arrives. Provides an address-match flag so the controller can stall a refill of a line still in flight.

Parameters:
- ADDR_WIDTH, 64, byte-address width
- BLOCK_WIDTH, 256, cache line width in bits (32 bytes, offset bits [4:0])
- AXI_BUS_WIDTH, 64, AXI W-channel data width; BEATS = BLOCK_WIDTH/AXI_BUS_WIDTH (default 4)
- LINE_OFFSET, 5, log2(BLOCK_WIDTH/8)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_wb_valid  in  1  victim line presented by controller
- o_wb_ready  out  1  buffer free; request accepted when i_wb_valid & o_wb_ready
- i_wb_addr  in  ADDR_WIDTH  victim line address; bits [LINE_OFFSET-1:0] ignored
- i_wb_block  in  BLOCK_WIDTH  victim line data, byte 0 at bits [7:0]
- i_lookup_addr  in  ADDR_WIDTH  refill/miss address to compare against held line
- o_lookup_hit  out  1  held line matches i_lookup_addr (combinational)
- o_wb_error  out  1  one-cycle pulse: B response was SLVERR/DECERR
- o_awvalid  out  1;  i_awready  in  1;  o_awaddr  out  ADDR_WIDTH;  o_awlen  out  8;  o_awsize  out  3;  o_awburst  out  2
- o_wvalid  out  1;  i_wready  in  1;  o_wdata  out  AXI_BUS_WIDTH;  o_wstrb  out  AXI_BUS_WIDTH/8;  o_wlast  out  1
- i_bvalid  in  1;  o_bready  out  1;  i_bresp  in  2

Behaviour:
- Reset is synchronous, i_rst=1 at a clock edge:
  - state goes to IDLE; beat counter, held address and held data go to 0.
  - All outputs are 0 except o_wb_ready, which is 1 in the first cycle after reset.
  - Reset mid-transaction abandons the burst with no response wait. The interconnect is reset with the same signal.
- FSM states: IDLE, ADDR, DATA, RESP.
  - IDLE: o_wb_ready=1. On i_wb_valid, capture {i_wb_addr[ADDR_WIDTH-1:LINE_OFFSET], LINE_OFFSET'b0} and i_wb_block, then go to ADDR.
  - ADDR: o_awvalid=1 with o_awaddr = held address, o_awlen = BEATS-1 (3), o_awsize = log2(AXI_BUS_WIDTH/8) (3), o_awburst = 2'b01 (INCR). Hold until i_awready, then go to DATA with beat=0.
  - DATA: o_wvalid=1, o_wdata = held[beat*AXI_BUS_WIDTH +: AXI_BUS_WIDTH], o_wstrb all ones, o_wlast = (beat==BEATS-1).
    - On i_wready: beat+1. On the last beat, go to RESP.
    - W never starts before AW has been accepted.
  - RESP: o_bready=1. On i_bvalid, go to IDLE. If i_bresp[1]=1, pulse o_wb_error for exactly the following cycle.
- AXI rules:
  - Valid stays asserted and payload stays stable until its handshake completes.
  - i_bvalid outside RESP is ignored (o_bready=0).
  - i_awready/i_wready asserted while the matching valid is 0 has no effect.
- Minimum latency:
  - Accept at cycle 0; AW at cycle 1; W beats at cycles 2-5; bready at cycle 6.
  - If bvalid arrives at cycle 6, o_wb_ready=1 at cycle 7.
  - No back-to-back acceptance: occupancy is one line.
- o_lookup_hit = (state != IDLE) && i_lookup_addr[ADDR_WIDTH-1:LINE_OFFSET] == held tag/index. It is 0 in IDLE even if the addresses are equal.
- Simultaneous events:
  - An i_wb_valid held while busy is not accepted. It is taken on the first IDLE cycle.
  - An error response still returns the FSM to IDLE. The data is dropped and the controller handles the error.

Decomposition:
- Shared dcache package holds:
  - AXI burst/size encodings (BURST_INCR=2'b01, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11)
  - the wb_state_t enum {IDLE, ADDR, DATA, RESP}
  - line geometry constants (LINE_OFFSET, BLOCK_WIDTH)
- Single module. Beat selection is an indexed part-select, so no sub-module is needed.

Test Plan:
- Reset, then a request with i_wb_addr=64'h8000_1234_5678_9A3F and block bytes 0x00..0x1F, all readies=1, bvalid at cycle 6 → awaddr=64'h8000_1234_5678_9A20, awlen=3, awsize=3, awburst=1. wdata beats: 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110, 64'h1F1E1D1C1B1A1918. wlast only on beat 3. o_wb_ready=1 at cycle 7.
- awready held 0 for 5 cycles → awvalid and awaddr stable throughout; no wvalid until the cycle after the AW handshake.
- wready toggling 1,0,0,1,1,0,1 → exactly 4 beats in order; wdata and wlast stable while stalled.
- bresp=2'b10 → o_wb_error=1 for one cycle; FSM returns to IDLE. bresp=2'b00 → no pulse.
- While busy: i_lookup_addr=held+0x1F → hit=1; held+0x20 → hit=0. In IDLE with the same address → hit=0. A second i_wb_valid is not accepted until IDLE.
- i_rst asserted in DATA at beat 2 → next cycle all valids=0, o_wb_ready=1; a new request then bursts correctly from beat 0.

Source files
------------

// File: rtl/riscv_core_dcache_writeback_buffer_pkg.sv
// Shared dcache definitions: AXI encodings, line geometry and the writeback FSM state type.
package riscv_core_dcache_writeback_buffer_pkg;

    localparam int unsigned DCACHE_LINE_OFFSET = 5;
    localparam int unsigned DCACHE_BLOCK_WIDTH = 256;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wb_state_t;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/riscv_core_dcache_writeback_buffer.sv
// Single-entry dirty-line writeback buffer: issues one held cache line as an AXI4 INCR write burst.
module riscv_core_dcache_writeback_buffer
    import riscv_core_dcache_writeback_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned BLOCK_WIDTH   = DCACHE_BLOCK_WIDTH,
    parameter int unsigned AXI_BUS_WIDTH = 64,
    parameter int unsigned LINE_OFFSET   = DCACHE_LINE_OFFSET
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wb_valid,
    output logic                       o_wb_ready,
    input  logic [ADDR_WIDTH-1:0]      i_wb_addr,
    input  logic [BLOCK_WIDTH-1:0]     i_wb_block,
    input  logic [ADDR_WIDTH-1:0]      i_lookup_addr,
    output logic                       o_lookup_hit,
    output logic                       o_wb_error,
    output logic                       o_awvalid,
    input  logic                       i_awready,
    output logic [ADDR_WIDTH-1:0]      o_awaddr,
    output logic [7:0]                 o_awlen,
    output logic [2:0]                 o_awsize,
    output logic [1:0]                 o_awburst,
    output logic                       o_wvalid,
    input  logic                       i_wready,
    output logic [AXI_BUS_WIDTH-1:0]   o_wdata,
    output logic [AXI_BUS_WIDTH/8-1:0] o_wstrb,
    output logic                       o_wlast,
    input  logic                       i_bvalid,
    output logic                       o_bready,
    input  logic [1:0]                 i_bresp
);

    localparam int unsigned BEATS  = BLOCK_WIDTH / AXI_BUS_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFFSET;

    wb_state_t               r_state;
    wb_state_t               w_next;
    logic [BEAT_W-1:0]       r_beat;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [BLOCK_WIDTH-1:0]  r_block;
    logic                    r_err;
    logic                    w_last_beat;

    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_addr  <= '0;
            r_block <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == RESP) && i_bvalid && resp_is_error(i_bresp);
            case (r_state)
                IDLE: if (i_wb_valid) begin
                    r_addr  <= i_wb_addr & LINE_MASK;
                    r_block <= i_wb_block;
                end
                ADDR: if (i_awready) r_beat <= '0;
                DATA: if (i_wready) r_beat <= r_beat + BEAT_W'(1);
                default: ;
            endcase
        end
    end

    // Payload fields are only driven in their own phase so idle outputs read as zero.
    always_comb begin
        w_next     = r_state;
        o_wb_ready = 1'b0;
        o_awvalid  = 1'b0;
        o_awaddr   = '0;
        o_awlen    = '0;
        o_awsize   = '0;
        o_awburst  = '0;
        o_wvalid   = 1'b0;
        o_wdata    = '0;
        o_wstrb    = '0;
        o_wlast    = 1'b0;
        o_bready   = 1'b0;
        case (r_state)
            IDLE: begin
                o_wb_ready = 1'b1;
                if (i_wb_valid) w_next = ADDR;
            end
            ADDR: begin
                o_awvalid = 1'b1;
                o_awaddr  = r_addr;
                o_awlen   = 8'(BEATS - 1);
                o_awsize  = 3'($clog2(AXI_BUS_WIDTH / 8));
                o_awburst = BURST_INCR;
                if (i_awready) w_next = DATA;
            end
            DATA: begin
                o_wvalid = 1'b1;
                o_wdata  = r_block[r_beat*AXI_BUS_WIDTH +: AXI_BUS_WIDTH];
                o_wstrb  = '1;
                o_wlast  = w_last_beat;
                if (i_wready && w_last_beat) w_next = RESP;
            end
            RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_wb_error   = r_err;
    assign o_lookup_hit = (r_state != IDLE) && ((i_lookup_addr & LINE_MASK) == r_addr);

endmodule
